dmem_responder: RTL and testbench

//  Data-memory responder: the far end of the core's MemWrite/ResultSrc load/store path.

---
 rtl/dmem_responder_pkg.sv | 35 +++
 rtl/dmem_lane_align.sv | 28 ++
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: store-size codes, FSM states
// and small lane helpers used by both the top level and the lane aligner.
package dmem_responder_pkg;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_B    = 2'b01;
    localparam logic [1:0] MW_H    = 2'b10;
    localparam logic [1:0] MW_W    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            MW_B:    m = 4'b0001;
            MW_H:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] a_lo);
        return ((size == MW_W) && (a_lo != 2'd0)) || ((size == MW_H) && (a_lo == 2'd3));
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane aligner: places store data/mask across a two-word window
// and extracts a little-endian load word from the {hi,lo} read pair.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [63:0] rd64,
    output logic [7:0]  mask8,
    output logic [63:0] data64,
    output logic [31:0] load_word,
    output logic        split
);

    logic [5:0]  sh_s;
    logic [63:0] rd_shift_s;

    always_comb begin
        sh_s       = {1'b0, addr_lo, 3'b000};
        mask8      = {4'b0000, size_mask(size)} << addr_lo;
        data64     = {32'd0, wdata} << sh_s;
        rd_shift_s = rd64 >> sh_s;
        load_word  = rd_shift_s[31:0];
        split      = crosses_word(size, addr_lo);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake against a word RAM, with
// word-crossing accesses split into two beats and one registered response each.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
    localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);

    logic [31:0] mem [0:DEPTH-1];

    state_e      state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        split_q, split_d;
    logic        bad_q, bad_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]    req_size_s;
    logic [1:0]    al_size_s;
    logic [1:0]    al_lo_s;
    logic [AW-1:0] cap_idx_s;
    logic [AW-1:0] req_idx_s;
    logic [AW-1:0] beat_idx_s;
    logic [31:0]   mem_rd_s;
    logic [63:0]   rd64_s;
    logic [7:0]    mask8_s;
    logic [63:0]   data64_s;
    logic [31:0]   load_word_s;
    logic          split_s;
    logic          req_oor_s;
    logic          we_s;
    logic [3:0]    wmask_s;
    logic [31:0]   wword_s;
    logic [31:0]   wbits_s;

    assign req_size_s = (mem_write != MW_NONE) ? mem_write : MW_W;
    assign cap_idx_s  = addr_q[AW+1:2];
    assign req_idx_s  = addr[AW+1:2];
    assign beat_idx_s = (state_q == S_BEAT1) ? (cap_idx_s + IDX_ONE) : cap_idx_s;
    assign mem_rd_s   = mem[beat_idx_s];
    assign rd64_s     = (state_q == S_BEAT1) ? {mem_rd_s, lo_q} : {32'd0, mem_rd_s};
    assign req_oor_s  = ((addr >> (AW + 2)) != 32'd0) || (split_s && (req_idx_s == LAST_IDX));
    assign wbits_s    = lane_bits(wmask_s);

    // While idle the aligner looks at the live request so the range check can use its split flag.
    always_comb begin
        if (state_q == S_IDLE) begin
            al_size_s = req_size_s;
            al_lo_s   = addr[1:0];
        end else begin
            al_size_s = size_q;
            al_lo_s   = addr_q[1:0];
        end
    end

    dmem_lane_align u_align (
        .size      (al_size_s),
        .addr_lo   (al_lo_s),
        .wdata     (wdata_q),
        .rd64      (rd64_s),
        .mask8     (mask8_s),
        .data64    (data64_s),
        .load_word (load_word_s),
        .split     (split_s)
    );

    // Next-state, capture, RAM beat control and response generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        split_d     = split_q;
        bad_d       = bad_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        we_s        = 1'b0;
        wmask_s     = 4'b0000;
        wword_s     = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && (mem_read || (mem_write != MW_NONE))) begin
                    state_d = S_BEAT0;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    size_d  = req_size_s;
                    rd_d    = mem_read;
                    wr_d    = (mem_write != MW_NONE);
                    split_d = split_s;
                    bad_d   = (mem_read && (mem_write != MW_NONE)) || req_oor_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BEAT0: begin
                lo_d    = mem_rd_s;
                we_s    = wr_q && !bad_q;
                wmask_s = mask8_s[3:0];
                wword_s = data64_s[31:0];
                if (split_q) begin
                    state_d = S_BEAT1;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    err_d       = bad_q;
                    rdata_d     = (rd_q && !bad_q) ? load_word_s : 32'd0;
                end
            end
            S_BEAT1: begin
                hi_d        = mem_rd_s;
                we_s        = wr_q && !bad_q;
                wmask_s     = mask8_s[7:4];
                wword_s     = data64_s[63:32];
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                err_d       = bad_q;
                rdata_d     = (rd_q && !bad_q) ? load_word_s : 32'd0;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, capture and response registers; reset drops any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            size_q      <= MW_NONE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            split_q     <= 1'b0;
            bad_q       <= 1'b0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            split_q     <= split_d;
            bad_q       <= bad_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // RAM contents survive reset; reset clears the beat state, which removes the enable at once.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[beat_idx_s] <= (mem[beat_idx_s] & ~wbits_s) | (wword_s & wbits_s);
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array reference model, directed
// scenarios, error/no-op cases, reset during a split store and randomized traffic.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam logic [31:0] TOP_BYTE = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [0:4*DEPTH-1];

    typedef struct {
        logic        rd;
        logic [1:0]  wr;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] k;
    } req_t;

    bit          e_rsp;
    int          e_lat;
    logic [31:0] e_rdata;
    logic        e_err;
    bit          o_rsp;
    bit          o_hs_ok;
    int          o_lat;
    logic [31:0] o_rdata;
    logic        o_err;

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: byte-addressed memory; a request either fits in range or is rejected whole.
    function automatic void model_req(input logic rd, input logic [1:0] wr,
                                      input logic [31:0] a, input logic [31:0] d);
        int     nb;
        longint first;
        longint last;
        bit     crosses;
        bit     bad;
        e_rsp   = 1'b0;
        e_lat   = 0;
        e_rdata = 32'd0;
        e_err   = 1'b0;
        if (rd == 1'b0 && wr == 2'b00) return;
        nb      = (wr == 2'b01) ? 1 : ((wr == 2'b10) ? 2 : 4);
        first   = longint'(a);
        last    = first + longint'(nb - 1);
        crosses = (first / longint'(4)) != (last / longint'(4));
        bad     = (rd == 1'b1 && wr != 2'b00) || (last >= longint'(4 * DEPTH));
        e_rsp   = 1'b1;
        e_lat   = crosses ? 3 : 2;
        e_err   = bad;
        if (!bad) begin
            if (wr != 2'b00) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(first) + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < 4; i++) e_rdata[8*i +: 8] = ref_mem[int'(first) + i];
            end
        end
    endfunction

    // Drive one request at a negedge, then watch the DUT; junk is driven while it is busy.
    task automatic issue(input logic rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
        int w;
        w       = 0;
        o_hs_ok = 1'b1;
        o_rsp   = 1'b0;
        o_lat   = 0;
        o_rdata = 32'd0;
        o_err   = 1'b0;
        while (req_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) o_hs_ok = 1'b0;
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        for (int c = 1; c <= 5 && !o_rsp; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                o_rsp     = 1'b1;
                o_lat     = c;
                o_rdata   = rdata;
                o_err     = err;
                req_valid = 1'b0;
                if (req_ready !== 1'b0) o_hs_ok = 1'b0;
            end else begin
                if (req_ready !== (e_rsp ? 1'b0 : 1'b1)) o_hs_ok = 1'b0;
                if (req_ready === 1'b0) begin
                    req_valid = 1'($urandom_range(0, 1));
                    mem_read  = 1'($urandom_range(0, 1));
                    mem_write = 2'($urandom_range(0, 3));
                    addr      = $urandom;
                    wdata     = $urandom;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        if (o_rsp) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) o_hs_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 2'b00;
        addr      = 32'd0;
        wdata     = 32'd0;
        repeat (3) @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [31:0] a;
        for (int w = 0; w < 72; w++) begin
            a = (w < 68) ? 32'(4 * w) : (TOP_BYTE - 32'(4 * (w - 67)));
            model_req(1'b0, 2'b11, a, $urandom);
            issue(1'b0, 2'b11, a, e_rdata ^ $urandom);
        end
        // Refill with known data so the model and DUT agree byte for byte.
        for (int w = 0; w < 72; w++) begin
            logic [31:0] d;
            a = (w < 68) ? 32'(4 * w) : (TOP_BYTE - 32'(4 * (w - 67)));
            d = $urandom;
            model_req(1'b0, 2'b11, a, d);
            issue(1'b0, 2'b11, a, d);
            n_tests++; if (o_rsp !== 1'b1 || o_err !== 1'b0 || o_hs_ok !== 1'b1) begin
                n_fail++; $display("FAIL fill[%0d] rsp %b err %b hs %b want 1 0 1", w, o_rsp, o_err, o_hs_ok);
            end
        end
    endtask

    task automatic test_directed();
        req_t t [8];
        t[0] = '{1'b0, 2'b11, 32'h10, 32'h11223344, 1'b0, 32'h0};
        t[1] = '{1'b1, 2'b00, 32'h10, 32'h0,        1'b1, 32'h11223344};
        t[2] = '{1'b0, 2'b01, 32'h13, 32'h000000AA, 1'b0, 32'h0};
        t[3] = '{1'b1, 2'b00, 32'h10, 32'h0,        1'b1, 32'hAA223344};
        t[4] = '{1'b0, 2'b11, 32'h22, 32'hDEADBEEF, 1'b0, 32'h0};
        t[5] = '{1'b1, 2'b00, 32'h20, 32'h0,        1'b0, 32'h0};
        t[6] = '{1'b1, 2'b00, 32'h24, 32'h0,        1'b0, 32'h0};
        t[7] = '{1'b1, 2'b00, 32'h22, 32'h0,        1'b1, 32'hDEADBEEF};
        for (int i = 0; i < 8; i++) begin
            model_req(t[i].rd, t[i].wr, t[i].a, t[i].d);
            issue(t[i].rd, t[i].wr, t[i].a, t[i].d);
            n_tests++; if (o_rsp !== e_rsp) begin n_fail++; $display("FAIL directed[%0d] rsp got %b want %b", i, o_rsp, e_rsp); end
            n_tests++; if (o_lat !== e_lat) begin n_fail++; $display("FAIL directed[%0d] latency got %0d want %0d", i, o_lat, e_lat); end
            n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL directed[%0d] rdata got %h want %h", i, o_rdata, e_rdata); end
            n_tests++; if (o_err !== e_err) begin n_fail++; $display("FAIL directed[%0d] err got %b want %b", i, o_err, e_err); end
            n_tests++; if (o_hs_ok !== 1'b1) begin n_fail++; $display("FAIL directed[%0d] handshake got %b want 1", i, o_hs_ok); end
            if (t[i].chk) begin
                n_tests++; if (o_rdata !== t[i].k) begin n_fail++; $display("FAIL directed[%0d] known_value got %h want %h", i, o_rdata, t[i].k); end
            end
        end
    endtask

    task automatic test_errors();
        req_t t [9];
        t[0] = '{1'b0, 2'b10, TOP_BYTE,              32'h0000BEEF, 1'b0, 32'h0};
        t[1] = '{1'b0, 2'b11, TOP_BYTE - 32'd2,      32'hCAFEBABE, 1'b0, 32'h0};
        t[2] = '{1'b1, 2'b00, TOP_BYTE - 32'd4,      32'h0,        1'b0, 32'h0};
        t[3] = '{1'b1, 2'b00, 32'h0,                 32'h0,        1'b0, 32'h0};
        t[4] = '{1'b1, 2'b11, 32'h30,                32'h55555555, 1'b0, 32'h0};
        t[5] = '{1'b1, 2'b00, 32'h30,                32'h0,        1'b0, 32'h0};
        t[6] = '{1'b1, 2'b00, TOP_BYTE - 32'd2,      32'h0,        1'b0, 32'h0};
        t[7] = '{1'b0, 2'b01, 32'hFFFF_FFF0,         32'h00000077, 1'b0, 32'h0};
        t[8] = '{1'b0, 2'b10, TOP_BYTE - 32'd1,      32'h00001234, 1'b0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            model_req(t[i].rd, t[i].wr, t[i].a, t[i].d);
            issue(t[i].rd, t[i].wr, t[i].a, t[i].d);
            n_tests++; if (o_rsp !== e_rsp) begin n_fail++; $display("FAIL errors[%0d] rsp got %b want %b", i, o_rsp, e_rsp); end
            n_tests++; if (o_lat !== e_lat) begin n_fail++; $display("FAIL errors[%0d] latency got %0d want %0d", i, o_lat, e_lat); end
            n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL errors[%0d] rdata got %h want %h", i, o_rdata, e_rdata); end
            n_tests++; if (o_err !== e_err) begin n_fail++; $display("FAIL errors[%0d] err got %b want %b", i, o_err, e_err); end
            n_tests++; if (o_hs_ok !== 1'b1) begin n_fail++; $display("FAIL errors[%0d] handshake got %b want 1", i, o_hs_ok); end
        end
    endtask

    task automatic test_noop();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63)) << 2;
            model_req(1'b0, 2'b00, a, $urandom);
            issue(1'b0, 2'b00, a, 32'hFFFFFFFF);
            n_tests++; if (o_rsp !== e_rsp) begin n_fail++; $display("FAIL noop[%0d] rsp got %b want %b", i, o_rsp, e_rsp); end
            n_tests++; if (o_hs_ok !== 1'b1) begin n_fail++; $display("FAIL noop[%0d] ready_held got %b want 1", i, o_hs_ok); end
            model_req(1'b1, 2'b00, a, 32'd0);
            issue(1'b1, 2'b00, a, 32'd0);
            n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL noop[%0d] ram_untouched got %h want %h", i, o_rdata, e_rdata); end
        end
    endtask

    task automatic test_reset_mid_split();
        int w;
        int seen;
        w = 0;
        while (req_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        mem_read  = 1'b0;
        mem_write = 2'b11;
        addr      = 32'h42;
        wdata     = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midsplit_ready_in_reset got %b want 1", req_ready); end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midsplit_no_rsp got %0d pulses want 0", seen); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midsplit_ready got %b want 1", req_ready); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midsplit_rdata_cleared got %h want 0", rdata); end
        ref_mem[32'h42] = 8'h0D;
        ref_mem[32'h43] = 8'hF0;
        model_req(1'b1, 2'b00, 32'h40, 32'd0);
        issue(1'b1, 2'b00, 32'h40, 32'd0);
        n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL midsplit_beat0_word got %h want %h", o_rdata, e_rdata); end
        n_tests++; if (o_rdata[31:16] !== 16'hF00D) begin n_fail++; $display("FAIL midsplit_beat0_lanes got %h want f00d", o_rdata[31:16]); end
        model_req(1'b1, 2'b00, 32'h44, 32'd0);
        issue(1'b1, 2'b00, 32'h44, 32'd0);
        n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL midsplit_beat1_word got %h want %h", o_rdata, e_rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic        rd;
            logic [1:0]  wr;
            logic [31:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 11);
            d    = $urandom;
            a    = 32'($urandom_range(0, 255));
            if (kind < 4) begin
                rd = 1'b1; wr = 2'b00;
            end else if (kind < 9) begin
                rd = 1'b0; wr = 2'($urandom_range(1, 3));
            end else if (kind == 9) begin
                rd = 1'b1; wr = 2'($urandom_range(1, 3));
            end else if (kind == 10) begin
                rd = 1'($urandom_range(0, 1)); wr = rd ? 2'b00 : 2'($urandom_range(1, 3));
                a  = ($urandom_range(0, 1) == 0) ? (TOP_BYTE - 32'($urandom_range(0, 3))) : ($urandom | 32'h8000_0000);
            end else begin
                rd = 1'b0; wr = 2'b00;
            end
            model_req(rd, wr, a, d);
            issue(rd, wr, a, d);
            n_tests++; if (o_rsp !== e_rsp) begin n_fail++; $display("FAIL random[%0d] rsp got %b want %b", i, o_rsp, e_rsp); end
            n_tests++; if (o_lat !== e_lat) begin n_fail++; $display("FAIL random[%0d] latency got %0d want %0d", i, o_lat, e_lat); end
            n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL random[%0d] rdata got %h want %h", i, o_rdata, e_rdata); end
            n_tests++; if (o_err !== e_err) begin n_fail++; $display("FAIL random[%0d] err got %b want %b", i, o_err, e_err); end
            n_tests++; if (o_hs_ok !== 1'b1) begin n_fail++; $display("FAIL random[%0d] handshake got %b want 1", i, o_hs_ok); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_errors();
        test_noop();
        test_reset_mid_split();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
